// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the cascaded BCD timer.
// Holds the digit width, the largest legal digit value, the FSM state type and the digit clamp.
package stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counter with load, up/down step and carry/borrow output.
// co is high when this digit is stepped while sitting on its wrap value.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    assign co = en && (dir ? (q == '0) : (q == BCD_MAX));

    always_ff @(posedge clk) begin
        if (r) begin
            q <= '0;
        end else if (ld) begin
            q <= clamp_digit(d);
        end else if (en) begin
            if (dir) begin
                q <= (q == '0) ? BCD_MAX : q - 1'b1;
            end else begin
                q <= (q == BCD_MAX) ? '0 : q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_timer_chain.sv
// Cascaded BCD up/down timer with start/stop control and tick prescaler.
// Define BCD_TIMER_SATURATE_EN to stop in DONE at the terminal value instead of wrapping.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | loaded or reset, waiting for s
//   ST_RUN   | counting one step per TICK_DIV tick pulses
//   ST_PAUSE | stopped by s, count and dir retained, divider cleared
//   ST_DONE  | terminal value reached (saturating build only), waits for ld
module bcd_timer_chain
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  tick,
    input  logic                  s,
    input  logic                  ld,
    input  logic                  dir,
    input  logic [BCD_W*DIGITS-1:0] preval,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                  running,
    output logic                  done
);

    localparam int CW = BCD_W * DIGITS;
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    state_t      state;
    logic [15:0] div_cnt;
    logic        step;
    logic        load_en;
    logic        hold;
    logic        stop_sat;
    logic        done_set;
    logic [DIGITS:0] chain;

    assign step    = (state == ST_RUN) && tick && (div_cnt == DIV_LAST);
    assign load_en = ld && (state != ST_RUN);

`ifdef BCD_TIMER_SATURATE_EN
    localparam logic [CW-1:0] ALL9  = {DIGITS{BCD_MAX}};
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] NEAR9 = ALL9 - ONE;

    logic at_term;
    logic pre_term;

    assign at_term  = dir ? (count == '0) : (count == ALL9);
    assign pre_term = dir ? (count == ONE) : (count == NEAR9);
    // A step from the terminal value itself holds the count rather than wrapping.
    assign hold     = step && at_term;
    assign stop_sat = step && (at_term || pre_term);
    assign done_set = stop_sat;
`else
    assign hold     = 1'b0;
    assign stop_sat = 1'b0;
    assign done_set = chain[DIGITS];
`endif

    assign chain[0] = step && !hold;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk (clk),
            .r   (r),
            .en  (chain[i]),
            .dir (dir),
            .ld  (load_en),
            .d   (preval[i*BCD_W +: BCD_W]),
            .q   (count[i*BCD_W +: BCD_W]),
            .co  (chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            div_cnt <= '0;
        end else if (load_en) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            div_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    div_cnt <= '0;
                    done    <= 1'b0;
                    if (s) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    done <= done_set;
                    if (s || stop_sat || step) begin
                        div_cnt <= '0;
                    end else if (tick) begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                    if (stop_sat) begin
                        state   <= ST_DONE;
                        running <= 1'b0;
                    end else if (s) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_DONE: begin
                    div_cnt <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Bench for bcd_timer_chain: two instances (TICK_DIV 1 and 3) on shared stimulus,
// checked every cycle against an integer-valued reference model, plus directed checks.
module tb_bcd_timer_chain;

`ifdef BCD_TIMER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        r, tick, s, ld, dir;
    logic [15:0] preval;
    logic [15:0] count1, count3;
    logic        running1, running3, done1, done3;

    int tests = 0;
    int fails = 0;

    int m_val [2];
    int m_st  [2];
    int m_div [2];
    bit m_done[2];
    int td    [2];

    always #5 clk = ~clk;

    bcd_timer_chain #(.DIGITS(4), .TICK_DIV(1)) dut1 (
        .clk(clk), .r(r), .tick(tick), .s(s), .ld(ld), .dir(dir),
        .preval(preval), .count(count1), .running(running1), .done(done1)
    );

    bcd_timer_chain #(.DIGITS(4), .TICK_DIV(3)) dut3 (
        .clk(clk), .r(r), .tick(tick), .s(s), .ld(ld), .dir(dir),
        .preval(preval), .count(count3), .running(running3), .done(done3)
    );

    function automatic int clamp_val(input logic [15:0] p);
        int v, w, d;
        v = 0;
        w = 1;
        for (int k = 0; k < 4; k++) begin
            d = int'(p[4*k +: 4]);
            if (d > 9) d = 9;
            v += d * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        int x;
        x = v;
        for (int k = 0; k < 4; k++) begin
            b[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    task automatic model_step(input int i);
        bit stepped, to_done;
        if (r) begin
            m_val[i] = 0; m_st[i] = M_IDLE; m_div[i] = 0; m_done[i] = 1'b0;
        end else if (ld && m_st[i] != M_RUN) begin
            m_val[i] = clamp_val(preval); m_st[i] = M_IDLE; m_div[i] = 0; m_done[i] = 1'b0;
        end else if (m_st[i] == M_RUN) begin
            stepped = tick && (m_div[i] + 1 == td[i]);
            to_done = 1'b0;
            if (!SAT) m_done[i] = 1'b0;
            if (stepped) begin
                if (SAT && (dir ? (m_val[i] <= 1) : (m_val[i] >= 9998))) begin
                    m_val[i]  = dir ? 0 : 9999;
                    to_done   = 1'b1;
                    m_done[i] = 1'b1;
                end else if (dir) begin
                    if (m_val[i] == 0) begin m_val[i] = 9999; m_done[i] = 1'b1; end
                    else m_val[i] = m_val[i] - 1;
                end else begin
                    if (m_val[i] == 9999) begin m_val[i] = 0; m_done[i] = 1'b1; end
                    else m_val[i] = m_val[i] + 1;
                end
            end
            if (to_done) m_st[i] = M_DONE;
            else if (s) m_st[i] = M_PAUSE;
            m_div[i] = (s || stepped) ? 0 : (tick ? m_div[i] + 1 : m_div[i]);
        end else begin
            if (!SAT) m_done[i] = 1'b0;
            if (s && m_st[i] != M_DONE) m_st[i] = M_RUN;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check("model_count_div1", count1,            to_bcd(m_val[0]));
        check("model_run_div1",   {15'b0, running1}, {15'b0, m_st[0] == M_RUN});
        check("model_done_div1",  {15'b0, done1},    {15'b0, m_done[0]});
        check("model_count_div3", count3,            to_bcd(m_val[1]));
        check("model_run_div3",   {15'b0, running3}, {15'b0, m_st[1] == M_RUN});
        check("model_done_div3",  {15'b0, done3},    {15'b0, m_done[1]});
    endtask

    task automatic step_in(input bit rr, input bit ll, input bit ss, input bit tt);
        r = rr; ld = ll; s = ss; tick = tt;
        cycle();
        r = 1'b0; ld = 1'b0; s = 1'b0; tick = 1'b0;
    endtask

    initial begin
        td[0] = 1;
        td[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_st[i] = M_IDLE; m_div[i] = 0; m_done[i] = 1'b0;
        end
        r = 1'b1; ld = 1'b0; s = 1'b0; tick = 1'b0; dir = 1'b1; preval = 16'h0000;

        // reset
        step_in(1, 0, 0, 0);
        check("rst_count",   count1, 16'h0000);
        check("rst_running", {15'b0, running1}, 16'h0000);
        check("rst_done",    {15'b0, done1},    16'h0000);

        // countdown from 0003
        preval = 16'h0003;
        step_in(0, 1, 0, 0);
        check("load_0003", count1, 16'h0003);
        step_in(0, 0, 1, 0);
        check("start_running", {15'b0, running1}, 16'h0001);
        step_in(0, 0, 0, 1);
        check("down_0002", count1, 16'h0002);
        step_in(0, 0, 0, 1);
        check("down_0001", count1, 16'h0001);
        step_in(0, 0, 0, 1);
        check("down_0000", count1, 16'h0000);
        check("done_at_zero", {15'b0, done1}, {15'b0, SAT});
        step_in(0, 0, 0, 1);
        check("tick4_count", count1, SAT ? 16'h0000 : 16'h9999);
        check("tick4_done",  {15'b0, done1}, 16'h0001);
        step_in(0, 0, 0, 1);
        check("tick5_count", count1, SAT ? 16'h0000 : 16'h9998);
        check("tick5_done",  {15'b0, done1}, {15'b0, SAT});
        check("div3_one_step", count3, 16'h0002);

        // borrow across two digits
        step_in(0, 0, 1, 0);
        check("stopped", {15'b0, running1}, 16'h0000);
        preval = 16'h0100;
        step_in(0, 1, 0, 0);
        step_in(0, 0, 1, 0);
        step_in(0, 0, 0, 1);
        check("borrow_0099", count1, 16'h0099);
        step_in(0, 0, 0, 1);
        step_in(0, 0, 0, 1);
        check("div3_borrow_0099", count3, 16'h0099);
        check("div1_0097", count1, 16'h0097);

        // clamp on load
        step_in(0, 0, 1, 0);
        preval = 16'hFA37;
        step_in(0, 1, 0, 0);
        check("clamp_div1", count1, 16'h9937);
        check("clamp_div3", count3, 16'h9937);

        // prescaler by 3, divider restart after stop/start
        dir = 1'b0;
        preval = 16'h0000;
        step_in(0, 1, 0, 0);
        step_in(0, 0, 1, 0);
        for (int k = 0; k < 6; k++) step_in(0, 0, 0, 1);
        check("div3_two_steps", count3, 16'h0002);
        check("div1_six_steps", count1, 16'h0006);
        step_in(0, 0, 0, 1);
        step_in(0, 0, 1, 0);
        step_in(0, 0, 1, 0);
        step_in(0, 0, 0, 1);
        step_in(0, 0, 0, 1);
        check("div3_restart_hold", count3, 16'h0002);
        step_in(0, 0, 0, 1);
        check("div3_restart_step", count3, 16'h0003);

        // s coinciding with a step
        step_in(0, 0, 1, 0);
        preval = 16'h0042;
        step_in(0, 1, 0, 0);
        step_in(0, 0, 1, 0);
        step_in(0, 0, 1, 1);
        check("s_tick_count", count1, 16'h0043);
        check("s_tick_pause", {15'b0, running1}, 16'h0000);
        step_in(0, 0, 0, 1);
        step_in(0, 0, 0, 1);
        check("pause_hold", count1, 16'h0043);

        // reset mid-RUN with tick and ld
        step_in(0, 0, 1, 0);
        step_in(0, 0, 0, 1);
        step_in(0, 0, 0, 1);
        step_in(1, 1, 0, 1);
        check("rst_mid_count",   count1, 16'h0000);
        check("rst_mid_running", {15'b0, running1}, 16'h0000);
        check("rst_mid_done",    {15'b0, done1},    16'h0000);
        check("rst_mid_count3",  count3, 16'h0000);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            preval = 16'($urandom);
            if ($urandom_range(15, 0) == 0) dir = ~dir;
            step_in($urandom_range(63, 0) == 0, $urandom_range(11, 0) == 0,
                    $urandom_range(7, 0) == 0,  $urandom_range(1, 0) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
